// File: rtl/snake_step_sched.sv
// Game-step scheduler: frame tick, non-reversing direction filter, paced move
// requests over req/ack, and game state / score tracking on the VGA clock.
module snake_step_sched #(
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter int unsigned H_LAST          = 639,
  parameter int unsigned V_LAST          = 479
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [3:0] key_out,
  input  logic       start,
  input  logic       step_ack,
  input  logic       collide,
  input  logic       eat,
  output logic       step_req,
  output logic [1:0] dir,
  output logic [1:0] game_state,
  output logic [7:0] score,
  output logic       frame_tick,
  output logic       overrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  localparam logic [5:0] CNT_LAST = 6'(FRAMES_PER_STEP - 1);
  localparam logic [9:0] H_LAST_C = 10'(H_LAST);
  localparam logic [9:0] V_LAST_C = 10'(V_LAST);
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  state_e     state_q, state_d;
  logic       match_q, match_d;
  logic       frame_tick_q, frame_tick_d;
  logic [5:0] cnt_q, cnt_d;
  logic       step_req_q, step_req_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] next_dir_q, next_dir_d;
  logic [7:0] score_q, score_d;
  logic       overrun_q, overrun_d;

  logic       ack_ok;
  logic       active;
  logic       hit;
  logic       step_due;
  logic       key_valid;
  logic [1:0] key_code;
  logic       start_game;

  // State register
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      match_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      cnt_q        <= '0;
      step_req_q   <= 1'b0;
      dir_q        <= DIR_RIGHT;
      next_dir_q   <= DIR_RIGHT;
      score_q      <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_q      <= match_d;
      frame_tick_q <= frame_tick_d;
      cnt_q        <= cnt_d;
      step_req_q   <= step_req_d;
      dir_q        <= dir_d;
      next_dir_q   <= next_dir_d;
      score_q      <= score_d;
      overrun_q    <= overrun_d;
    end
  end

  assign ack_ok = step_ack && step_req_q;
  assign active = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign hit    = ack_ok && collide && active;

  // Next-state logic: a colliding ack overrides any start in the same cycle
  always_comb begin
    state_d = state_q;
    if (hit) begin
      state_d = ST_OVER;
    end else if (start) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        ST_OVER:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    key_code = 2'b00;
    case (key_out)
      4'b0010: key_code = 2'b01;
      4'b0100: key_code = 2'b10;
      4'b1000: key_code = 2'b11;
      default: ;
    endcase
  end

  assign key_valid  = $onehot(key_out) && (state_q == ST_RUN);
  assign step_due   = (state_q == ST_RUN) && frame_tick_q && (cnt_q == CNT_LAST);
  assign start_game = (state_q == ST_IDLE) && (state_d == ST_RUN);

  // Datapath / output next values
  always_comb begin
    match_d      = (pix_x == H_LAST_C) && (pix_y == V_LAST_C);
    frame_tick_d = match_d && !match_q;
    cnt_d        = cnt_q;
    step_req_d   = step_req_q;
    dir_d        = dir_q;
    next_dir_d   = next_dir_q;
    score_d      = score_q;
    overrun_d    = overrun_q;

    if ((state_q == ST_RUN) && frame_tick_q)
      cnt_d = step_due ? '0 : cnt_q + 6'd1;

    if (ack_ok)
      step_req_d = 1'b0;

    // A request still pending (even if acked this cycle) blocks a new launch
    if (step_due) begin
      if (step_req_q) begin
        overrun_d = 1'b1;
      end else begin
        step_req_d = 1'b1;
        dir_d      = next_dir_q;
      end
    end

    if (key_valid && (key_code != {dir_q[1], ~dir_q[0]}))
      next_dir_d = key_code;

    if (ack_ok && active && !collide && eat && (score_q != 8'hFF))
      score_d = score_q + 8'd1;

    if (start_game) begin
      score_d    = '0;
      cnt_d      = '0;
      overrun_d  = 1'b0;
      dir_d      = DIR_RIGHT;
      next_dir_d = DIR_RIGHT;
    end
  end

  always_comb begin
    step_req   = step_req_q;
    dir        = dir_q;
    game_state = state_q;
    score      = score_q;
    frame_tick = frame_tick_q;
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_snake_step_sched.sv
// Bench for snake_step_sched: every-cycle comparison against a behavioural
// game model, a direction-filter vector table, and directed corner sequences.
module tb_snake_step_sched;

  localparam int FPS = 8;

  logic       clk;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic [3:0] key_out;
  logic       start, step_ack, collide, eat;
  logic       step_req;
  logic [1:0] dir;
  logic [1:0] game_state;
  logic [7:0] score;
  logic       frame_tick;
  logic       overrun;

  snake_step_sched #(
    .FRAMES_PER_STEP(FPS),
    .H_LAST(639),
    .V_LAST(479)
  ) dut (
    .vga_clk   (clk),
    .sys_rst_n (rst_n),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .key_out   (key_out),
    .start     (start),
    .step_ack  (step_ack),
    .collide   (collide),
    .eat       (eat),
    .step_req  (step_req),
    .dir       (dir),
    .game_state(game_state),
    .score     (score),
    .frame_tick(frame_tick),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model of the game
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_OVER = 3;
  int m_state = M_IDLE, m_score = 0, m_dir = 3, m_next = 3, m_frames = 0;
  bit m_req = 0, m_tick = 0, m_over = 0, m_prev = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int  n_state, n_score, n_dir, n_next, n_frames, code;
    bit  n_req, n_over, match, due, took, playing;
    if (!rst_n) begin
      m_state = M_IDLE; m_score = 0; m_dir = 3; m_next = 3; m_frames = 0;
      m_req = 0; m_tick = 0; m_over = 0; m_prev = 0;
      return;
    end
    match   = (pix_x == 10'd639) && (pix_y == 10'd479);
    playing = (m_state == M_RUN) || (m_state == M_PAUSE);
    due     = (m_state == M_RUN) && m_tick && (m_frames == FPS - 1);
    took    = step_ack && m_req;
    n_state = m_state; n_score = m_score; n_dir = m_dir; n_next = m_next;
    n_frames = m_frames; n_req = m_req; n_over = m_over;

    if (m_state == M_RUN && m_tick) n_frames = due ? 0 : m_frames + 1;
    if (took) n_req = 0;
    if (due) begin
      if (m_req) n_over = 1;
      else begin n_req = 1; n_dir = m_next; end
    end
    if (m_state == M_RUN && $countones(key_out) == 1) begin
      code = 0;
      for (int b = 0; b < 4; b++) if (key_out[b]) code = b;
      if (code != (m_dir ^ 1)) n_next = code;
    end
    if (took && playing && !collide && eat) n_score = (m_score < 255) ? m_score + 1 : 255;
    if (took && playing && collide) n_state = M_OVER;
    else if (start) begin
      case (m_state)
        M_IDLE: begin
          n_state = M_RUN; n_score = 0; n_frames = 0; n_over = 0; n_dir = 3; n_next = 3;
        end
        M_RUN:   n_state = M_PAUSE;
        M_PAUSE: n_state = M_RUN;
        default: n_state = M_IDLE;
      endcase
    end

    m_tick = match && !m_prev;
    m_prev = match;
    m_state = n_state; m_score = n_score; m_dir = n_dir; m_next = n_next;
    m_frames = n_frames; m_req = n_req; m_over = n_over;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    chk("step_req",   int'(step_req),   int'(m_req));
    chk("dir",        int'(dir),        m_dir);
    chk("game_state", int'(game_state), m_state);
    chk("score",      int'(score),      m_score);
    chk("frame_tick", int'(frame_tick), int'(m_tick));
    chk("overrun",    int'(overrun),    int'(m_over));
  endtask

  task automatic idle_inputs();
    pix_x = '0; pix_y = '0; key_out = '0;
    start = 0; step_ack = 0; collide = 0; eat = 0;
  endtask

  task automatic pulse_start();
    start = 1; cyc(); start = 0;
  endtask

  task automatic do_ack(input bit c, input bit e);
    step_ack = 1; collide = c; eat = e;
    cyc();
    step_ack = 0; collide = 0; eat = 0;
  endtask

  // 4-cycle frames: coordinate match on the first cycle of each frame
  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < 4; c++) begin
        pix_x = (c == 0) ? 10'd639 : 10'd0;
        pix_y = (c == 0) ? 10'd479 : 10'd0;
        cyc();
      end
    end
    pix_x = '0; pix_y = '0;
  endtask

  task automatic do_step();
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      pix_x = (i % 4 == 0) ? 10'd639 : 10'd0;
      pix_y = (i % 4 == 0) ? 10'd479 : 10'd0;
      cyc();
      if (step_req) seen = 1;
    end
    pix_x = '0; pix_y = '0;
    chk("step_req_timeout", int'(seen), 1);
  endtask

  typedef struct {
    logic [3:0] key;
    logic [1:0] exp_dir;
  } dir_vec_t;
  dir_vec_t vecs[10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] d;
    vecs[0] = '{4'b0100, 2'b11};
    vecs[1] = '{4'b0001, 2'b00};
    vecs[2] = '{4'b0101, 2'b00};
    vecs[3] = '{4'b0010, 2'b00};
    vecs[4] = '{4'b1000, 2'b11};
    vecs[5] = '{4'b0000, 2'b11};
    vecs[6] = '{4'b1111, 2'b11};
    vecs[7] = '{4'b0010, 2'b01};
    vecs[8] = '{4'b0001, 2'b01};
    vecs[9] = '{4'b0100, 2'b10};

    idle_inputs();
    rst_n = 0;
    cyc(); cyc();
    chk("rst_step_req", int'(step_req), 0);
    chk("rst_dir", int'(dir), 3);
    chk("rst_state", int'(game_state), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1;
    cyc();

    // Start, first step, eat
    pulse_start();
    chk("start_state", int'(game_state), 1);
    chk("start_dir", int'(dir), 3);
    do_step();
    chk("first_req", int'(step_req), 1);
    do_ack(0, 1);
    chk("ack_req_clear", int'(step_req), 0);
    chk("ack_score", int'(score), 1);

    // Direction filter table
    for (int v = 0; v < 10; v++) begin
      key_out = vecs[v].key; cyc(); key_out = '0;
      do_step();
      d = dir;
      chk($sformatf("dir_vec%0d", v), int'(d), int'(vecs[v].exp_dir));
      do_ack(0, 0);
    end

    // Withheld ack -> overrun, single outstanding request
    do_step();
    run_frames(9);
    chk("overrun_set", int'(overrun), 1);
    chk("overrun_req", int'(step_req), 1);
    do_ack(0, 0);
    chk("overrun_ack_req", int'(step_req), 0);
    chk("overrun_sticky", int'(overrun), 1);

    // Pause with pending request, collide, restart
    do_step();
    pulse_start();
    chk("pause_state", int'(game_state), 2);
    chk("pause_req", int'(step_req), 1);
    run_frames(3);
    do_ack(1, 1);
    chk("collide_state", int'(game_state), 3);
    chk("collide_score", int'(score), 1);
    pulse_start();
    chk("over_idle", int'(game_state), 0);
    chk("idle_score_kept", int'(score), 1);
    pulse_start();
    chk("restart_state", int'(game_state), 1);
    chk("restart_score", int'(score), 0);
    chk("restart_overrun", int'(overrun), 0);

    // Score saturation
    for (int s = 0; s < 256; s++) begin
      do_step();
      do_ack(0, 1);
    end
    chk("score_sat", int'(score), 255);

    // Reset mid-handshake
    do_step();
    rst_n = 0; cyc(); rst_n = 1;
    chk("midrst_req", int'(step_req), 0);
    chk("midrst_state", int'(game_state), 0);
    chk("midrst_score", int'(score), 0);
    chk("midrst_dir", int'(dir), 3);
    do_ack(0, 1);
    chk("late_ack_score", int'(score), 0);
    chk("late_ack_req", int'(step_req), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom % 1000) != 0;
      if ($urandom % 4 == 0) begin
        pix_x = 10'd639; pix_y = 10'd479;
      end else begin
        pix_x = 10'($urandom); pix_y = 10'($urandom);
      end
      key_out  = ($urandom % 8 == 0) ? 4'($urandom) : 4'b0000;
      start    = ($urandom % 80 == 0);
      step_ack = ($urandom % 3 == 0);
      collide  = ($urandom % 25 == 0);
      eat      = $urandom % 2;
      if (game_state == 2'b00 && $urandom % 10 == 0) start = 1;
      cyc();
    end
    idle_inputs();
    rst_n = 1;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/snake_step_sched.md
# snake_step_sched

Game-step scheduler for the snake VGA design. Runs on the 25 MHz VGA clock alongside the timing controller and picture generator. It derives a once-per-frame tick from the pixel coordinates and converts the debounced key bus into a non-reversing direction. It then issues one move request per FRAMES_PER_STEP frames to the picture/datapath block over a req/ack handshake, and tracks the game state, score and collision-driven game over.

## Interface
- FRAMES_PER_STEP, 8: frames between move requests; legal range 1..63.
- H_LAST, 639: pix_x value marking the last active column.
- V_LAST, 479: pix_y value marking the last active row.
- vga_clk  in  1  single clock for the block (25 MHz).
- sys_rst_n  in  1  reset; synchronous, active-low.
- pix_x  in  10  current active-area X coordinate from the VGA timing controller.
- pix_y  in  10  current active-area Y coordinate.
- key_out  in  4  debounced direction keys, one-hot: [0] up, [1] down, [2] left, [3] right.
- start  in  1  single-cycle start/pause/restart pulse.
- step_ack  in  1  datapath accepted the move; collide/eat are valid in this cycle.
- collide  in  1  the move hit a wall or the body; qualified by step_ack.
- eat  in  1  the move consumed food; qualified by step_ack.
- step_req  out  1  move request; held high until acknowledged.
- dir  out  2  direction of the current move: 00 up, 01 down, 10 left, 11 right.
- game_state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER.
- score  out  8  food count; saturates at 255.
- frame_tick  out  1  one-cycle pulse at end of the active frame.
- overrun  out  1  sticky flag: a step was due while step_req was still pending.

## Operation
- Frame tick: compare (pix_x==H_LAST && pix_y==V_LAST) and register the result. frame_tick pulses on the first cycle the comparison is true after a cycle where it was false. It pulses in every state.
- Direction filter:
  - key_out is ignored unless it is exactly one-hot and game_state==RUN.
  - A valid key loads next_dir unless it is the reverse of dir (up/down, left/right). Reverse keys are dropped.
  - A key equal to dir is accepted and has no effect.
- Step scheduler, counting in RUN only:
  - A 6-bit frame counter increments on frame_tick. On the tick where count==FRAMES_PER_STEP-1, the counter clears and a step is due.
  - If step_req is low when a step is due: step_req goes high and dir loads next_dir in the same edge. dir holds stable while step_req is high.
  - If step_req is already high when a step is due: no new request, overrun sets, counter still clears.
- Handshake:
  - step_req clears on the edge after step_ack is sampled high with step_req high.
  - step_ack while step_req is low is ignored, including its collide/eat.
- Ack processing, in RUN or PAUSE:
  - collide=1 → OVER; score unchanged even if eat=1.
  - Otherwise eat=1 → score+1, saturating at 255.
- State machine, transitions on start:
  - IDLE→RUN: score, counter and overrun clear; dir and next_dir load right (11).
  - RUN→PAUSE: frame counter freezes. A pending step_req stays high and its ack is still processed, including collide→OVER.
  - PAUSE→RUN: counter resumes from its frozen value.
  - OVER→IDLE: score is retained until the next IDLE→RUN.
- Simultaneous events:
  - Ack with collide and start in the same cycle: OVER wins and start is ignored.
  - Ack without collide and start in the same cycle: both are applied (score update plus state change).
  - Key and step launch in the same cycle: the launched step uses the old next_dir; the key updates next_dir for the following step.
  - Step due and ack of the previous request in the same cycle: counts as pending, so overrun sets and no new request is issued.

## Timing
- Reset values: step_req 0, dir 11, game_state IDLE, score 0, frame_tick 0, overrun 0. Internal counter and next_dir reset to 0 and 11.
- Reset asserted mid-handshake drops step_req on the next edge, with no ack required.
- frame_tick rises 1 cycle after the coordinate match.
- step_req rises 1 cycle after the qualifying frame_tick.
- game_state, score and step_req update 1 cycle after the ack cycle.
- start and key effects are visible 1 cycle after sampling.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then start pulse → game_state 01, dir 11. With FRAMES_PER_STEP=8, step_req rises 1 cycle after the 8th frame_tick; ack with collide=0, eat=1 → step_req 0, score 1.
- In RUN with dir=11: key_out=0100 (left) → dir stays 11 on the next step. key_out=0001 (up) → next step dir=00. key_out=0101 → ignored.
- Withhold step_ack for 9 frames → overrun=1, exactly one step_req outstanding. Ack → step_req 0 next cycle; overrun stays 1 until IDLE→RUN.
- Start in RUN with step_req high → PAUSE; step_req stays high. Ack with collide=1 → game_state 11. Start → IDLE with score retained; start → RUN with score 0.
- Drive 256 acks with eat=1 → score saturates at 255.
- Assert sys_rst_n low for 1 cycle during a pending request → all outputs at reset values next edge; an ack arriving afterwards is ignored.
